mem_wb_stage: RTL
=================

// Module: mem_wb_stage
// PURPOSE
//  Memory-access/write-back stage of the LEGv8 datapath. Sits downstream of the ALU and
//  upstream of the register file (Operand_Prep write port).
//  Takes ALU_Result, Read_data2 and controller flags (MemRead/MemWrite/MemtoReg/RegWrite).
//  Runs the data-cache access over a req/ack handshake, then presents one registered
//  write-back beat per instruction. Deasserts ex_ready while a cache access is in flight.
// PARAMETERS
//  DATA_W   32  datapath / cache data width
//  REG_W    5   register index width
//  TIMEOUT  15  max cycles cache_req stays high without cache_ack before bus error (1..255)
// PORTS
//  clock          in   1       single clock, rising edge
//  reset          in   1       synchronous, active-high
//  ex_valid       in   1       ALU stage presents an instruction this cycle
//  ex_ready       out  1       stage accepts; transfer when ex_valid & ex_ready at edge
//  ex_alu_result  in   DATA_W  ALU_Result: effective address or result
//  ex_store_data  in   DATA_W  Read_data2: store data
//  ex_rd          in   REG_W   destination register (Instruction[4:0])
//  ex_mem_read    in   1       MemRead
//  ex_mem_write   in   1       MemWrite
//  ex_mem_to_reg  in   1       MemtoReg: write-back selects load data
//  ex_reg_write   in   1       RegWrite
//  cache_req      out  1       cache request, held until cache_ack
//  cache_we       out  1       1 = store, 0 = load
//  cache_addr     out  DATA_W  word-aligned address
//  cache_wdata    out  DATA_W  store data
//  cache_ack      in   1       cache completes request this cycle
//  cache_rdata    in   DATA_W  load data, valid with cache_ack
//  wb_valid       out  1       one-cycle write-back beat
//  wb_reg_write   out  1       register-file write enable (qualified by wb_valid)
//  wb_rd          out  REG_W   write-back register index
//  wb_data        out  DATA_W  write-back data
//  exc_misalign   out  1       pulse with wb_valid: memory op had addr[1:0] != 0
//  exc_bus_err    out  1       pulse with wb_valid: cache timeout
// BEHAVIOUR
//  - FSM: IDLE, MEM, WB. ex_ready = ~reset & (state != MEM).
//  - Accept in IDLE or WB:
//      no mem op             -> WB
//      mem op, aligned       -> MEM
//      mem op, misaligned    -> WB, exc_misalign=1, no cache request
//    In WB with no accept -> IDLE. Non-memory throughput is 1 instr/cycle.
//  - Capture at accept: rd, alu_result, store_data and flags into holding registers.
//    ex_mem_write & ex_mem_read both set: treated as a store.
//  - MEM: cache_req=1; cache_we, cache_addr, cache_wdata stable from holding registers
//    until the ack cycle.
//      cache_ack at edge          -> capture cache_rdata, go to WB
//      ack in first MEM cycle     -> legal, 1-cycle access
//  - Timeout: cycle counter clears on MEM entry. If TIMEOUT MEM cycles pass without ack:
//    drop cache_req, go to WB with exc_bus_err=1. Late acks in IDLE/WB are ignored.
//  - WB outputs, registered, valid during the WB cycle:
//      wb_data      = mem_to_reg ? load data : alu_result
//      wb_reg_write = reg_write & (rd != 31) & ~exc_misalign & ~exc_bus_err
//    Writes to XZR (x31) are suppressed.
//  - Latency, accept at edge k:
//      non-mem op             -> wb_valid in cycle k+1
//      mem op, ack at edge m  -> wb_valid in cycle m+1
//  - Stores: wb_valid still pulses; wb_reg_write=0 unless RegWrite is set.
//  - Reset (any state, incl. mid-MEM):
//      next cycle: state=IDLE; wb_*, cache_*, exc_* = 0; timeout counter = 0
//      ex_ready=0 while reset is high
//      in-flight access abandoned, no write-back beat
// TESTING
//  1 ADD path: accept alu_result=0x0000_0007, rd=3, reg_write=1, no mem
//      -> cycle k+1: wb_valid=1, wb_rd=3, wb_data=7, wb_reg_write=1
//  2 LDUR: addr=0x40, ack after 3 cycles with rdata=0xDEAD_BEEF, mem_to_reg=1, rd=5
//      -> cache_req high 3 cycles, addr stable 0x40, ex_ready=0 throughout
//      -> then wb_data=0xDEAD_BEEF, wb_rd=5
//  3 STUR: addr=0x44, store_data=0x1234, ack in first MEM cycle
//      -> cache_we=1, cache_wdata=0x1234 for 1 cycle; wb_valid=1, wb_reg_write=0
//  4 Misaligned LDUR addr=0x42
//      -> no cache_req; next cycle wb_valid=1, exc_misalign=1, wb_reg_write=0
//  5 Timeout: LDUR with cache_ack held 0
//      -> cache_req high exactly 15 cycles, then wb_valid with exc_bus_err=1
//  6 Edge cases:
//      rd=31 ADD                      -> wb_reg_write=0
//      4 back-to-back ADDs            -> 4 consecutive wb_valid cycles
//      reset in 2nd MEM cycle         -> cache_req=0 and no wb_valid afterwards

Source files
------------

// File: rtl/mem_wb_stage.sv
// LEGv8 memory-access / write-back stage: runs one data-cache access per memory
// instruction over req/ack and emits one registered write-back beat per instruction.
module mem_wb_stage #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned REG_W   = 5,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [DATA_W-1:0] ex_alu_result,
  input  logic [DATA_W-1:0] ex_store_data,
  input  logic [REG_W-1:0]  ex_rd,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic              ex_mem_to_reg,
  input  logic              ex_reg_write,
  output logic              cache_req,
  output logic              cache_we,
  output logic [DATA_W-1:0] cache_addr,
  output logic [DATA_W-1:0] cache_wdata,
  input  logic              cache_ack,
  input  logic [DATA_W-1:0] cache_rdata,
  output logic              wb_valid,
  output logic              wb_reg_write,
  output logic [REG_W-1:0]  wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              exc_misalign,
  output logic              exc_bus_err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MEM  = 2'd1;
  localparam logic [1:0] S_WB   = 2'd2;

  localparam int unsigned      CNT_W    = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [REG_W-1:0] XZR      = REG_W'(31);

  logic [1:0]        state, state_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic [REG_W-1:0]  h_rd, h_rd_d;
  logic [DATA_W-1:0] h_alu, h_alu_d;
  logic              h_mem_to_reg, h_mem_to_reg_d;
  logic              h_reg_write, h_reg_write_d;

  logic              cache_req_d, cache_we_d;
  logic [DATA_W-1:0] cache_addr_d, cache_wdata_d;
  logic              wb_valid_d, wb_reg_write_d, exc_misalign_d, exc_bus_err_d;
  logic [REG_W-1:0]  wb_rd_d;
  logic [DATA_W-1:0] wb_data_d;

  logic accept, ex_mem_op, ex_misaligned;

  assign ex_ready      = ~reset & (state != S_MEM);
  assign accept        = ex_valid & ex_ready;
  assign ex_mem_op     = ex_mem_read | ex_mem_write;
  assign ex_misaligned = ex_alu_result[1:0] != 2'b00;

  // Next-state and next-output logic; the write-back beat is launched on the edge entering WB.
  always_comb begin
    state_d        = state;
    cnt_d          = cnt;
    h_rd_d         = h_rd;
    h_alu_d        = h_alu;
    h_mem_to_reg_d = h_mem_to_reg;
    h_reg_write_d  = h_reg_write;
    cache_req_d    = cache_req;
    cache_we_d     = cache_we;
    cache_addr_d   = cache_addr;
    cache_wdata_d  = cache_wdata;
    wb_valid_d     = 1'b0;
    wb_reg_write_d = 1'b0;
    exc_misalign_d = 1'b0;
    exc_bus_err_d  = 1'b0;
    wb_rd_d        = wb_rd;
    wb_data_d      = wb_data;

    case (state)
      S_MEM: begin
        if (cache_ack) begin
          state_d        = S_WB;
          cache_req_d    = 1'b0;
          cache_we_d     = 1'b0;
          cache_addr_d   = '0;
          cache_wdata_d  = '0;
          wb_valid_d     = 1'b1;
          wb_rd_d        = h_rd;
          wb_data_d      = h_mem_to_reg ? cache_rdata : h_alu;
          wb_reg_write_d = h_reg_write & (h_rd != XZR);
        end else if (cnt == CNT_LAST) begin
          state_d       = S_WB;
          cache_req_d   = 1'b0;
          cache_we_d    = 1'b0;
          cache_addr_d  = '0;
          cache_wdata_d = '0;
          wb_valid_d    = 1'b1;
          exc_bus_err_d = 1'b1;
          wb_rd_d       = h_rd;
          wb_data_d     = h_mem_to_reg ? '0 : h_alu;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      default: begin
        if (accept) begin
          h_rd_d         = ex_rd;
          h_alu_d        = ex_alu_result;
          h_mem_to_reg_d = ex_mem_to_reg;
          h_reg_write_d  = ex_reg_write;
          if (!ex_mem_op) begin
            state_d        = S_WB;
            wb_valid_d     = 1'b1;
            wb_rd_d        = ex_rd;
            wb_data_d      = ex_alu_result;
            wb_reg_write_d = ex_reg_write & (ex_rd != XZR);
          end else if (ex_misaligned) begin
            state_d        = S_WB;
            wb_valid_d     = 1'b1;
            exc_misalign_d = 1'b1;
            wb_rd_d        = ex_rd;
            wb_data_d      = ex_mem_to_reg ? '0 : ex_alu_result;
          end else begin
            // A read+write op is issued as a store.
            state_d       = S_MEM;
            cnt_d         = '0;
            cache_req_d   = 1'b1;
            cache_we_d    = ex_mem_write;
            cache_addr_d  = ex_alu_result;
            cache_wdata_d = ex_store_data;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= S_IDLE;
      cnt          <= '0;
      h_rd         <= '0;
      h_alu        <= '0;
      h_mem_to_reg <= 1'b0;
      h_reg_write  <= 1'b0;
      cache_req    <= 1'b0;
      cache_we     <= 1'b0;
      cache_addr   <= '0;
      cache_wdata  <= '0;
      wb_valid     <= 1'b0;
      wb_reg_write <= 1'b0;
      wb_rd        <= '0;
      wb_data      <= '0;
      exc_misalign <= 1'b0;
      exc_bus_err  <= 1'b0;
    end else begin
      state        <= state_d;
      cnt          <= cnt_d;
      h_rd         <= h_rd_d;
      h_alu        <= h_alu_d;
      h_mem_to_reg <= h_mem_to_reg_d;
      h_reg_write  <= h_reg_write_d;
      cache_req    <= cache_req_d;
      cache_we     <= cache_we_d;
      cache_addr   <= cache_addr_d;
      cache_wdata  <= cache_wdata_d;
      wb_valid     <= wb_valid_d;
      wb_reg_write <= wb_reg_write_d;
      wb_rd        <= wb_rd_d;
      wb_data      <= wb_data_d;
      exc_misalign <= exc_misalign_d;
      exc_bus_err  <= exc_bus_err_d;
    end
  end

endmodule
